// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the main-memory access unit: default widths,
// request op codes and the controller state encoding.
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 11;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_WAIT = 3'd2,
        ST_WR   = 3'd3,
        CP_RD   = 3'd4,
        CP_WAIT = 3'd5,
        CP_WR   = 3'd6,
        DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Initiator for the 1024x16 main memory. Accepts load / store / block-copy
// requests over a valid/ready handshake, drives the memory ports, captures
// read data under the memory's one-cycle registered read latency and returns
// one response per request.
//
// State table:
//   state   | meaning
//   IDLE    | req_ready high, waiting for a request
//   LD_RD   | load: read strobe on addr
//   LD_WAIT | load: memory returns data, captured at end of cycle
//   ST_WR   | store: write strobe on addr with wdata
//   CP_RD   | copy: read strobe on src+i
//   CP_WAIT | copy: memory returns word i, captured at end of cycle
//   CP_WR   | copy: write word i to dst+i, then i++
//   DONE    | one-cycle response pulse
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               request handshake and payload
//   resp_*              one-cycle response (rdata held until next response)
//   busy                high whenever not IDLE
//   mem_*               memory address/data/strobes and read data return
//
// Every output is a flop loaded from the decode of the next state, so each
// strobe/address is valid for exactly the cycle spent in its state.
// ----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_in
);

    state_e            state, state_n;
    logic [1:0]        op_q, op_n;
    logic [ADDR_W-1:0] src_q, src_n;
    logic [ADDR_W-1:0] dst_q, dst_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] word_q, word_n;

    logic              take;
    logic              ready_n;
    logic              busy_n;
    logic              re_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] dout_n;
    logic              resp_valid_n;
    logic [DATA_W-1:0] resp_rdata_n;
    logic              resp_error_n;

    // req_ready is low for the first cycle out of reset, so no handshake can
    // land on that edge even though the state is already IDLE.
    assign take = (state == IDLE) && req_valid && req_ready;

    always_comb begin
        state_n = state;
        op_n    = op_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        wdata_n = wdata_q;
        word_n  = word_q;

        case (state)
            IDLE: begin
                if (take) begin
                    op_n    = req_op;
                    src_n   = req_addr;
                    dst_n   = req_dst;
                    len_n   = req_len;
                    wdata_n = req_wdata;
                    cnt_n   = '0;
                    // A zero-length copy reports no stale word from an
                    // earlier request.
                    word_n  = '0;
                    case (req_op)
                        OP_LOAD:  state_n = LD_RD;
                        OP_STORE: state_n = ST_WR;
                        OP_COPY:  state_n = (req_len == '0) ? DONE : CP_RD;
                        default:  state_n = DONE;
                    endcase
                end
            end
            LD_RD: begin
                state_n = LD_WAIT;
            end
            LD_WAIT: begin
                word_n  = mem_data_in;
                state_n = DONE;
            end
            ST_WR: begin
                state_n = DONE;
            end
            CP_RD: begin
                state_n = CP_WAIT;
            end
            CP_WAIT: begin
                word_n  = mem_data_in;
                state_n = CP_WR;
            end
            CP_WR: begin
                cnt_n   = cnt_q + LEN_W'(1);
                state_n = (cnt_n == len_q) ? DONE : CP_RD;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode of the state about to be entered.
    always_comb begin
        ready_n      = (state_n == IDLE);
        busy_n       = (state_n != IDLE);
        re_n         = (state_n == LD_RD) || (state_n == CP_RD);
        we_n         = (state_n == ST_WR) || (state_n == CP_WR);
        addr_n       = '0;
        dout_n       = '0;
        resp_valid_n = (state_n == DONE);
        resp_rdata_n = resp_rdata;
        resp_error_n = 1'b0;

        case (state_n)
            LD_RD:   addr_n = src_n;
            ST_WR:   addr_n = src_n;
            CP_RD:   addr_n = src_n + ADDR_W'(cnt_n);
            CP_WR:   addr_n = dst_n + ADDR_W'(cnt_n);
            default: addr_n = '0;
        endcase

        case (state_n)
            ST_WR:   dout_n = wdata_n;
            CP_WR:   dout_n = word_n;
            default: dout_n = '0;
        endcase

        if (state_n == DONE) begin
            resp_error_n = (op_n == OP_RSVD);
            if ((op_n == OP_LOAD) || (op_n == OP_COPY)) begin
                resp_rdata_n = word_n;
            end else begin
                resp_rdata_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op_q             <= OP_LOAD;
            src_q            <= '0;
            dst_q            <= '0;
            len_q            <= '0;
            cnt_q            <= '0;
            wdata_q          <= '0;
            word_q           <= '0;
            req_ready        <= 1'b0;
            busy             <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_error       <= 1'b0;
            mem_address      <= '0;
            mem_data_out     <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
        end else begin
            state            <= state_n;
            op_q             <= op_n;
            src_q            <= src_n;
            dst_q            <= dst_n;
            len_q            <= len_n;
            cnt_q            <= cnt_n;
            wdata_q          <= wdata_n;
            word_q           <= word_n;
            req_ready        <= ready_n;
            busy             <= busy_n;
            resp_valid       <= resp_valid_n;
            resp_rdata       <= resp_rdata_n;
            resp_error       <= resp_error_n;
            mem_address      <= addr_n;
            mem_data_out     <= dout_n;
            mem_write_enable <= we_n;
            mem_read_enable  <= re_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit with a behavioural 1024x16 memory
// (registered read, one-cycle latency). Expected responses are queued when a
// request is handshaken and compared (latency, rdata, error) when resp_valid
// appears. A background monitor watches the memory strobes.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_dst;
    logic [LW-1:0] req_len;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_out;
    logic          mem_write_enable;
    logic          mem_read_enable;
    logic [DW-1:0] mem_data_in;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_dst          (req_dst),
        .req_len          (req_len),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .busy             (busy),
        .mem_address      (mem_address),
        .mem_data_out     (mem_data_out),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_in      (mem_data_in)
    );

    logic [DW-1:0] mem [0:1023];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_data_out;
        if (mem_read_enable)  mem_data_in <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_rd;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] rd_log[$];
    int            checks    = 0;
    int            errors    = 0;
    int            en_count  = 0;
    logic          re_prev   = 1'b0;
    logic          we_prev   = 1'b0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (mem_read_enable && mem_write_enable) begin
                errors++;
                $display("FAIL en_overlap cyc=%0d re=1 we=1 required not both", cyc);
            end
            checks++;
            if ((mem_read_enable && re_prev) || (mem_write_enable && we_prev)) begin
                errors++;
                $display("FAIL en_pulse cyc=%0d re=%b/%b we=%b/%b required single-cycle strobes",
                         cyc, re_prev, mem_read_enable, we_prev, mem_write_enable);
            end
            if (mem_read_enable) begin
                rd_log.push_back(mem_address);
                en_count++;
            end
            if (mem_write_enable) en_count++;
            re_prev = mem_read_enable;
            we_prev = mem_write_enable;
            if (resp_valid) begin
                checks++;
                if (mem_read_enable || mem_write_enable) begin
                    errors++;
                    $display("FAIL en_in_done cyc=%0d re=%b we=%b required 0",
                             cyc, mem_read_enable, mem_write_enable);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected cyc=%0d got response, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL resp_latency got cyc %0d required cyc %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (resp_error !== e.err) begin
                        errors++;
                        $display("FAIL resp_error got %b required %b", resp_error, e.err);
                    end
                    if (e.chk_rd) begin
                        checks++;
                        if (resp_rdata !== e.rdata) begin
                            errors++;
                            $display("FAIL resp_rdata got %h required %h", resp_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    endtask

    // Issues one request; hs is the cycle count at the negedge just before
    // the handshake edge. The response is due lat cycles after that.
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] d, input logic [LW-1:0] len,
                          input logic [DW-1:0] wd, input int lat,
                          input logic [DW-1:0] rd, input logic er,
                          input bit chk_rd, input bit push, output int hs);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(negedge clk);
        req_op    = op;
        req_addr  = a;
        req_dst   = d;
        req_len   = len;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (req_ready) got = 1'b1;
            else @(negedge clk);
        end
        hs = cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout op=%0d req_ready=0 required 1", op);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            e.cyc    = cyc + lat;
            e.rdata  = rd;
            e.err    = er;
            e.chk_rd = chk_rd;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_LOAD;
        req_addr  = '0;
        req_dst   = '0;
        req_len   = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b busy=%b resp=%b required 0 0 0",
                     req_ready, busy, resp_valid);
        end
        checks++;
        if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_en re=%b we=%b required 0 0", mem_read_enable, mem_write_enable);
        end
        checks++;
        if (resp_rdata !== 16'h0 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp rdata=%h err=%b required 0000 0", resp_rdata, resp_error);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_store_load();
        int hs;
        do_req(OP_STORE, 10'd5, 10'd0, 11'd0, 16'h1234, 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_LOAD,  10'd5, 10'd0, 11'd0, 16'h0,    3, 16'h1234, 1'b0, 1'b1, 1'b1, hs);
        wait_drain();
    endtask

    task automatic test_signed_wrap();
        int hs;
        do_req(OP_STORE, 10'd1023, 10'd0, 11'd0, 16'hFFFE, 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_LOAD,  10'd1023, 10'd0, 11'd0, 16'h0,    3, 16'hFFFE, 1'b0, 1'b1, 1'b1, hs);
        wait_drain();
        checks++;
        if ($signed(resp_rdata) !== -16'sd2) begin
            errors++;
            $display("FAIL signed_hold got %0d required -2", $signed(resp_rdata));
        end
    endtask

    task automatic test_copy();
        int            hs;
        logic [DW-1:0] v [3];
        v[0] = 16'd7; v[1] = 16'hFFF8; v[2] = 16'd9;
        for (int i = 0; i < 3; i++)
            do_req(OP_STORE, AW'(10 + i), 10'd0, 11'd0, v[i], 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_COPY, 10'd10, 10'd20, 11'd3, 16'h0, 10, 16'd9, 1'b0, 1'b1, 1'b1, hs);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[20 + i] !== v[i]) begin
                errors++;
                $display("FAIL copy_mem[%0d] got %h required %h", 20 + i, mem[20 + i], v[i]);
            end
        end
        // Overlapping forward copy propagates the first word.
        for (int i = 0; i < 3; i++)
            do_req(OP_STORE, AW'(30 + i), 10'd0, 11'd0, DW'(5 + i), 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_COPY, 10'd30, 10'd31, 11'd3, 16'h0, 10, 16'd5, 1'b0, 1'b1, 1'b1, hs);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[31 + i] !== 16'd5) begin
                errors++;
                $display("FAIL overlap_mem[%0d] got %h required 0005", 31 + i, mem[31 + i]);
            end
        end
    endtask

    task automatic test_copy_wrap();
        int            hs;
        logic [AW-1:0] src [4];
        src[0] = 10'd1022; src[1] = 10'd1023; src[2] = 10'd0; src[3] = 10'd1;
        for (int i = 0; i < 4; i++)
            do_req(OP_STORE, src[i], 10'd0, 11'd0, DW'(16'h0A01 + i), 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        wait_drain();
        rd_log.delete();
        do_req(OP_COPY, 10'd1022, 10'd100, 11'd4, 16'h0, 13, 16'h0A04, 1'b0, 1'b1, 1'b1, hs);
        wait_drain();
        checks++;
        if (rd_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_reads count got %0d required 4", rd_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[i] !== src[i]) begin
                    errors++;
                    $display("FAIL wrap_read[%0d] got %0d required %0d", i, rd_log[i], src[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[100 + i] !== DW'(16'h0A01 + i)) begin
                errors++;
                $display("FAIL wrap_mem[%0d] got %h required %h", 100 + i, mem[100 + i],
                         DW'(16'h0A01 + i));
            end
        end
    endtask

    task automatic test_zero_rsvd();
        int hs;
        wait_drain();
        en_count = 0;
        do_req(OP_COPY, 10'd10, 10'd50, 11'd0, 16'h0, 1, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_RSVD, 10'd10, 10'd50, 11'd3, 16'h0, 1, 16'h0, 1'b1, 1'b0, 1'b1, hs);
        wait_drain();
        repeat (2) @(negedge clk);
        checks++;
        if (en_count != 0) begin
            errors++;
            $display("FAIL zero_rsvd_access strobes got %0d required 0", en_count);
        end
    endtask

    task automatic test_back_to_back();
        int  hs;
        int  r;
        bit  got;
        exp_t e;
        got = 1'b0;
        r   = 0;
        // mem[10..11] = 7, -8 from the copy test; mem[21] = -8.
        do_req(OP_COPY, 10'd10, 10'd40, 11'd2, 16'h0, 7, 16'hFFF8, 1'b0, 1'b1, 1'b1, hs);
        req_op    = OP_LOAD;
        req_addr  = 10'd21;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                r   = cyc;
            end
        end
        checks++;
        if (!got || r != hs + 8) begin
            errors++;
            $display("FAIL held_accept got ready at cyc %0d required cyc %0d", r, hs + 8);
        end
        if (got) begin
            e.cyc = r + 3; e.rdata = 16'hFFF8; e.err = 1'b0; e.chk_rd = 1'b1;
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_drain();
        checks++;
        if (mem[40] !== 16'd7 || mem[41] !== 16'hFFF8) begin
            errors++;
            $display("FAIL b2b_mem got %h %h required 0007 fff8", mem[40], mem[41]);
        end
    endtask

    task automatic test_reset_midcopy();
        int hs;
        for (int i = 0; i < 5; i++)
            do_req(OP_STORE, AW'(200 + i), 10'd0, 11'd0, DW'(11 + i), 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_STORE, 10'd300, 10'd0, 11'd0, 16'd99, 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        do_req(OP_STORE, 10'd301, 10'd0, 11'd0, 16'd99, 2, 16'h0, 1'b0, 1'b0, 1'b1, hs);
        wait_drain();
        do_req(OP_COPY, 10'd200, 10'd300, 11'd5, 16'h0, 16, 16'h0, 1'b0, 1'b0, 1'b0, hs);
        repeat (4) @(negedge clk);
        checks++;
        if (cyc != hs + 5 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL cp_wait_phase cyc=%0d re=%b we=%b required cyc %0d re=0 we=0",
                     cyc, mem_read_enable, mem_write_enable, hs + 5);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_en re=%b we=%b resp=%b required 0 0 0",
                     mem_read_enable, mem_write_enable, resp_valid);
        end
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl ready=%b busy=%b required 0 0", req_ready, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready ready=%b busy=%b required 1 0", req_ready, busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (mem[300] !== 16'd11 || mem[301] !== 16'd99) begin
            errors++;
            $display("FAIL abort_mem got %h %h required 000b 0063", mem[300], mem[301]);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_store_load();
        test_signed_wrap();
        test_copy();
        test_copy_wrap();
        test_zero_rsvd();
        test_back_to_back();
        test_reset_midcopy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator for the 1024x16 main memory. It accepts load, store and block-copy requests from the processor datapath over a valid/ready handshake and drives the memory's address, data, write-enable and read-enable ports. It captures read data under the memory's one-cycle registered read latency and returns one response per request. It sits between the execute stage and main_memory.

Parameters:
ADDR_W, 10, memory address width (depth 2^ADDR_W words)
DATA_W, 16, signed data word width
LEN_W, 11, copy length width (0..1024 words)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_op  in  2  00 load, 01 store, 10 copy, 11 reserved
req_addr  in  ADDR_W  load/store address; copy source base
req_dst  in  ADDR_W  copy destination base
req_len  in  LEN_W  copy length in words
req_wdata  in  DATA_W  signed store data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load data; for copy, last word copied
resp_error  out  1  valid with resp_valid; reserved op
busy  out  1  not IDLE
mem_address  out  ADDR_W  to memory address
mem_data_out  out  DATA_W  to memory data_in
mem_write_enable  out  1  to memory write_enable
mem_read_enable  out  1  to memory read_enable
mem_data_in  in  DATA_W  from memory data_out

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - All state updates on posedge clk.
  - While reset is sampled high at an edge, all outputs go to 0 (resp_rdata=0, req_ready=0, mem enables=0) and state goes to IDLE.
  - First cycle after reset deasserts: req_ready=1.
- All outputs are registered.
- Memory model: memory samples read_enable at an edge and updates data_out at that edge. The unit samples mem_data_in at the end of the cycle after the read-enable cycle.
- FSM states: IDLE, LD_RD, LD_WAIT, ST_WR, CP_RD, CP_WAIT, CP_WR, DONE.
- IDLE:
  - req_ready=1. A handshake is req_valid&&req_ready at an edge.
  - On handshake, latch op/addr/dst/len/wdata and set req_ready=0.
  - Next state by op:
    - load -> LD_RD
    - store -> ST_WR
    - copy with len>0 -> CP_RD
    - copy with len=0 -> DONE
    - reserved -> DONE with error flag
- LD_RD: mem_read_enable=1, mem_address=addr for exactly one cycle -> LD_WAIT.
- LD_WAIT: enables 0; capture mem_data_in into rdata at end of cycle -> DONE.
- ST_WR: mem_write_enable=1, mem_address=addr, mem_data_out=wdata for exactly one cycle -> DONE.
- CP_RD / CP_WAIT / CP_WR: one word per 3 cycles.
  - CP_RD reads src+i.
  - CP_WAIT captures the word.
  - CP_WR writes it to dst+i, then increments i.
  - If i==len, go to DONE; else back to CP_RD.
- DONE: resp_valid=1 for one cycle with resp_rdata and resp_error; req_ready=0 -> IDLE.
- Latency from handshake edge to resp_valid cycle:
  - load 3
  - store 2
  - copy 3*len+1
  - len=0 or reserved op: 1
- Invariants:
  - mem_read_enable and mem_write_enable are never high together.
  - Enables are 0 in IDLE and DONE.
  - No memory access for reserved op or len=0.
- Address arithmetic is modulo 2^ADDR_W; src+i and dst+i wrap 1023->0.
- Copy runs in ascending order. With overlapping regions and dst>src, already-written words are re-read (forward-copy semantics, not memmove).
- req_valid while busy is ignored; there is no queueing. The requester holds the request until req_ready.
- resp has no backpressure.
- resp_rdata holds its value until the next response; resp_error is 0 except in a reserved-op DONE.
- Data is signed 16-bit, passed through unmodified; no extension or truncation.
- Reset mid-operation aborts immediately:
  - Enables drop at that edge.
  - Words already written stay written.
  - No response is issued.

Decomposition:
- Shared package mem_pkg:
  - op code constants OP_LOAD, OP_STORE, OP_COPY, OP_RSVD
  - ADDR_W/DATA_W/LEN_W defaults
  - FSM state encoding
- No sub-module. FSM plus address/count registers stay flat in one module; main_memory is instantiated only in the bench.

Test Plan:
- After reset: store 16'h1234 to addr 5, then load addr 5 -> store resp 2 cycles after handshake; load resp 3 cycles after with rdata=16'h1234, error=0.
- Store -2 to addr 1023, load 1023 -> rdata=16'hFFFE (signed -2). Check the enable pulses are exactly one cycle each and never overlapping.
- Preload mem[10..12]=7,-8,9; copy src=10 dst=20 len=3 -> mem[20..22]=7,-8,9; resp_valid 10 cycles after handshake; rdata=9.
- Copy src=1022 dst=100 len=4 -> reads 1022,1023,0,1 in order; mem[100..103] match.
- Copy len=0 and op=11 -> resp in 1 cycle with no mem enables; error=0 and 1 respectively. A req_valid held during a copy is not accepted until IDLE.
- Assert reset during CP_WAIT of a len=5 copy -> enables 0 from the next cycle, no resp_valid, req_ready=1 the cycle after reset drops. Earlier copied words remain.
